pc_predict_unit: RTL and testbench
==================================

# pc_predict_unit

Registered fetch-PC generator with a parametrised 2-bit branch history table (BHT), compressed-instruction (16-bit) sequencing and a jalr-wait state machine. It sits at the front of the pipeline. It owns the PC register, predicts conditional branches at fetch, and redirects on EX-stage mispredicts and jalr resolution. It generalises the combinational next-PC mux with a stored PC, dynamic prediction and halfword PC steps.

## Interface
- XLEN, 32, PC/immediate width
- BHT_IDX_W, 4, log2 of BHT entries (16)
- C_EXT, 1, 1 enables +2 sequencing for compressed instructions
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC (downstream backpressure)
- if_is_c  in  1  fetched instruction is 16-bit
- if_branch  in  1  fetched instruction is a conditional branch
- if_jal  in  1  fetched instruction is jal
- if_jalr  in  1  fetched instruction is jalr
- if_imm  in  XLEN  sign-extended branch/jal offset
- ex_br_valid  in  1  conditional branch resolved in EX this cycle
- ex_pc  in  XLEN  PC of the resolved branch
- ex_taken  in  1  actual branch outcome
- ex_mispredict  in  1  prediction for the EX branch was wrong
- ex_redirect_pc  in  XLEN  correct next PC computed by EX
- ex_jalr_valid  in  1  jalr target resolved this cycle
- ex_jalr_target  in  XLEN  jalr target (bit 0 already cleared)
- pc_o  out  XLEN  current fetch PC (registered)
- pc_fall_o  out  XLEN  pc_o + 2 or + 4
- pred_taken_o  out  1  prediction for the instruction at pc_o
- jalr_wait_o  out  1  fetch held, awaiting jalr target
- flush_o  out  1  squash IF/ID contents this cycle

## Operation
- Next-PC priority, highest first: rst -> RESET_PC; ex_mispredict -> ex_redirect_pc; ex_jalr_valid in JALR_WAIT -> ex_jalr_target; stall -> hold; JALR_WAIT -> hold; if_jal or (if_branch & pred_taken_o) -> pc_o + if_imm; if_jalr -> hold and enter JALR_WAIT; else pc_fall_o.
- pc_fall_o = pc_o + 2 when C_EXT & if_is_c, else pc_o + 4. All adds wrap modulo 2^XLEN. pc_o[0] is always 0.
- pred_taken_o = if_branch & ctr[pc_o[BHT_IDX_W:1]][1]. It is combinational from the registered PC and the counter array.
- BHT update occurs when ex_br_valid is high. Index = ex_pc[BHT_IDX_W:1]. Taken saturates up toward 11; not-taken saturates down toward 00. Update is independent of stall.
- FSM states: RUN and JALR_WAIT.
  - RUN -> JALR_WAIT on if_jalr & !stall & !ex_mispredict.
  - JALR_WAIT -> RUN on ex_jalr_valid or ex_mispredict.
- flush_o = ex_mispredict | (ex_jalr_valid & state==JALR_WAIT). It is combinational and lasts the same cycle as the cause.
- Reset values: pc_o=RESET_PC, state=RUN, all counters=01 (weakly not-taken), jalr_wait_o=0, pred_taken_o=0, flush_o=0 while no EX inputs are asserted.

## Timing
- pc_o changes one cycle after the deciding inputs. Redirect latency is 1 cycle: ex_mispredict in cycle N gives pc_o=ex_redirect_pc in N+1.
- BHT read and update to the same index in the same cycle: the read sees the old value, with no bypass. The updated value is visible in the next cycle.
- ex_mispredict overrides stall, jalr wait and any IF-side decode in the same cycle.
- ex_mispredict and ex_jalr_valid asserted together: mispredict wins, the jalr target is ignored, and the state returns to RUN.
- ex_jalr_valid in RUN is ignored.
- rst asserted mid-JALR_WAIT or mid-stall resets everything in that edge. The first post-reset fetch is RESET_PC.

## Structure
- Shared package pc_pkg holds:
  - counter encoding constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - the FSM state typedef (RUN, JALR_WAIT);
  - the PC increment constants 2 and 4.
- One sub-module, pc_bht: 2^BHT_IDX_W by 2-bit counter array with one combinational read port and one synchronous saturating-update port, reset to WNT.
- The top level holds the PC register, the next-PC priority mux and the FSM.

## Test plan
- Reset sequencing: rst then release, with a 32-bit non-branch, a 16-bit non-branch, then a 32-bit non-branch -> pc_o = 0, 4, 6, 10.
- Prediction training: branch at PC 0x40 with if_imm=-16, resolved taken twice via ex_br_valid -> counter 01->10->11, and the next fetch of 0x40 gives pred_taken_o=1 and next pc_o=0x30.
- Mispredict with stall: stall=1 and ex_mispredict=1 with ex_redirect_pc=0x200 -> flush_o=1 that cycle, pc_o=0x200 next cycle.
- jalr wait: jalr at 0x80 -> pc_o holds 0x80 with jalr_wait_o=1 for 3 cycles; ex_jalr_valid with target 0x1000 -> flush_o=1, then pc_o=0x1000 and state RUN.
- Boundaries:
  - PC wrap: pc_o=0xFFFF_FFFC with 32-bit instruction -> pc_o=0.
  - Counter saturation: five not-taken updates from 01 -> stays 00.
  - Same-cycle read/update at one index -> pred_taken_o uses the pre-update value.
- Reset in JALR_WAIT: rst pulse -> pc_o=RESET_PC, jalr_wait_o=0, all counters WNT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC predictor: BHT counter encodings,
// fetch FSM states, PC step sizes and the saturating counter update.
package pc_pkg;

  // 2-bit branch history counter encodings
  localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] WT  = 2'b10;  // weakly taken
  localparam logic [1:0] ST  = 2'b11;  // strongly taken

  // Fetch FSM: RUN fetches normally, JALR_WAIT holds the PC until EX
  // produces the indirect target.
  typedef enum logic {
    RUN       = 1'b0,
    JALR_WAIT = 1'b1
  } pc_state_e;

  // Sequential PC increments for 16-bit and 32-bit instructions
  localparam int unsigned PC_INC_C = 2;
  localparam int unsigned PC_INC_W = 4;

  // Saturating 2-bit counter step toward ST on taken, toward SNT otherwise
  function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_bht.sv
// Branch history table: 2^IDX_W saturating 2-bit counters with one
// combinational read port and one synchronous update port. A read and an
// update to the same index in one cycle returns the old value (no bypass).
module pc_bht
  import pc_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr [DEPTH];

  // Combinational read of the counter selected by the fetch PC
  always_comb begin
    rd_ctr = ctr[rd_idx];
  end

  // Reset every counter to weakly not-taken; otherwise apply resolved outcomes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= WNT;
      end
    end else if (upd_en) begin
      ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC generator: owns the PC register, predicts conditional branches
// with a 2-bit BHT, steps by 2 or 4 bytes, and holds fetch while a jalr
// target is outstanding. EX-stage mispredicts and jalr resolution redirect.
//
// Handshake note: there is no valid/ready pair here. stall is a level
// backpressure hold sampled every cycle; ex_br_valid / ex_jalr_valid are
// single-cycle strobes that are consumed in the cycle they are high and
// never wait for acknowledgement.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          BHT_IDX_W = 4,
  parameter int          C_EXT     = 1,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            if_is_c,
  input  logic            if_branch,
  input  logic            if_jal,
  input  logic            if_jalr,
  input  logic [XLEN-1:0] if_imm,
  input  logic            ex_br_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic            ex_mispredict,
  input  logic [XLEN-1:0] ex_redirect_pc,
  input  logic            ex_jalr_valid,
  input  logic [XLEN-1:0] ex_jalr_target,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_fall_o,
  output logic            pred_taken_o,
  output logic            jalr_wait_o,
  output logic            flush_o
);

  localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] STEP_C = XLEN'(PC_INC_C);
  localparam logic [XLEN-1:0] STEP_W = XLEN'(PC_INC_W);

  logic [XLEN-1:0] pc_q;
  pc_state_e       state_q;
  logic [1:0]      rd_ctr;
  logic [XLEN-1:0] pc_target;
  logic            unused_bits;

  // Low PC bit is architecturally zero; the dropped bits are collected here
  assign unused_bits = ^{ex_pc[XLEN-1:BHT_IDX_W+1], ex_pc[0],
                         ex_redirect_pc[0], ex_jalr_target[0], if_imm[0]};

  pc_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc_q[BHT_IDX_W:1]),
    .rd_ctr    (rd_ctr),
    .upd_en    (ex_br_valid),
    .upd_idx   (ex_pc[BHT_IDX_W:1]),
    .upd_taken (ex_taken)
  );

  // Sequential successor, prediction, taken target and squash decode
  always_comb begin
    pc_fall_o    = pc_q + (((C_EXT != 0) && if_is_c) ? STEP_C : STEP_W);
    pc_target    = pc_q + {if_imm[XLEN-1:1], 1'b0};
    pred_taken_o = if_branch & rd_ctr[1];
    flush_o      = ex_mispredict | (ex_jalr_valid & (state_q == JALR_WAIT));
  end

  assign pc_o        = pc_q;
  assign jalr_wait_o = (state_q == JALR_WAIT);

  // PC register and fetch FSM, following the next-PC priority chain
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RST_PC;
      state_q <= RUN;
    end else if (ex_mispredict) begin
      pc_q    <= {ex_redirect_pc[XLEN-1:1], 1'b0};
      state_q <= RUN;
    end else if (ex_jalr_valid && (state_q == JALR_WAIT)) begin
      pc_q    <= {ex_jalr_target[XLEN-1:1], 1'b0};
      state_q <= RUN;
    end else if (stall || (state_q == JALR_WAIT)) begin
      pc_q    <= pc_q;
      state_q <= state_q;
    end else if (if_jal || (if_branch && rd_ctr[1])) begin
      pc_q    <= pc_target;
      state_q <= RUN;
    end else if (if_jalr) begin
      pc_q    <= pc_q;
      state_q <= JALR_WAIT;
    end else begin
      pc_q    <= pc_fall_o;
      state_q <= RUN;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit: expected PCs are queued as each
// cycle's stimulus is driven and popped after the clock edge.
module tb_pc_predict_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            stall;
  logic            if_is_c;
  logic            if_branch;
  logic            if_jal;
  logic            if_jalr;
  logic [XLEN-1:0] if_imm;
  logic            ex_br_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic            ex_mispredict;
  logic [XLEN-1:0] ex_redirect_pc;
  logic            ex_jalr_valid;
  logic [XLEN-1:0] ex_jalr_target;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_fall_o;
  logic            pred_taken_o;
  logic            jalr_wait_o;
  logic            flush_o;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model_pc;
  int              n_cmp;
  int              n_err;

  pc_predict_unit #(
    .XLEN      (32),
    .BHT_IDX_W (4),
    .C_EXT     (1),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .if_is_c        (if_is_c),
    .if_branch      (if_branch),
    .if_jal         (if_jal),
    .if_jalr        (if_jalr),
    .if_imm         (if_imm),
    .ex_br_valid    (ex_br_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect_pc (ex_redirect_pc),
    .ex_jalr_valid  (ex_jalr_valid),
    .ex_jalr_target (ex_jalr_target),
    .pc_o           (pc_o),
    .pc_fall_o      (pc_fall_o),
    .pred_taken_o   (pred_taken_o),
    .jalr_wait_o    (jalr_wait_o),
    .flush_o        (flush_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    stall          = 1'b0;
    if_is_c        = 1'b0;
    if_branch      = 1'b0;
    if_jal         = 1'b0;
    if_jalr        = 1'b0;
    if_imm         = '0;
    ex_br_valid    = 1'b0;
    ex_pc          = '0;
    ex_taken       = 1'b0;
    ex_mispredict  = 1'b0;
    ex_redirect_pc = '0;
    ex_jalr_valid  = 1'b0;
    ex_jalr_target = '0;
  endtask

  // Let combinational outputs settle after inputs change (well before negedge)
  task automatic settle();
    #1;
  endtask

  // Queue the PC expected after this edge, clock, then pop and compare
  task automatic tick(input string tag, input logic [31:0] exp_pc);
    logic [31:0] exp_v;
    exp_q.push_back(exp_pc);
    model_pc = exp_pc;
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check_eq(tag, pc_o, exp_v);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    clear_in();
    ex_mispredict  = 1'b1;
    ex_redirect_pc = target;
    tick("redirect", target);
    clear_in();
  endtask

  task automatic check_all_wnt(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_eq(tag, 32'(dut.u_bht.ctr[i]), 32'h1);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    model_pc = '0;
    clear_in();

    // Reset sequencing
    rst = 1'b1;
    tick("rst_pc0", 32'h0);
    if_branch = 1'b1;
    tick("rst_pc1", 32'h0);
    settle();
    check_eq("rst_pred", 32'(pred_taken_o), 32'h0);
    check_eq("rst_jwait", 32'(jalr_wait_o), 32'h0);
    check_eq("rst_flush", 32'(flush_o), 32'h0);
    check_all_wnt("rst_ctr");
    if_branch = 1'b0;
    rst = 1'b0;
    tick("seq_w0", 32'h4);
    if_is_c = 1'b1;
    settle();
    check_eq("fall_c", pc_fall_o, 32'h6);
    tick("seq_c", 32'h6);
    if_is_c = 1'b0;
    tick("seq_w1", 32'hA);

    // Random sequential run of mixed 16/32-bit instructions
    for (int i = 0; i < 20; i++) begin
      if_is_c = 1'($urandom_range(0, 1));
      tick("rand_seq", model_pc + (if_is_c ? 32'd2 : 32'd4));
    end
    clear_in();

    // Prediction training at 0x40, imm -16; stall holds the fetch PC
    redirect_to(32'h40);
    stall       = 1'b1;
    if_branch   = 1'b1;
    if_imm      = 32'hFFFF_FFF0;
    ex_br_valid = 1'b1;
    ex_pc       = 32'h40;
    ex_taken    = 1'b1;
    settle();
    check_eq("pred_same_cycle_old", 32'(pred_taken_o), 32'h0);
    tick("train1", 32'h40);
    check_eq("ctr_wt", 32'(dut.u_bht.ctr[0]), 32'h2);
    check_eq("pred_after_wt", 32'(pred_taken_o), 32'h1);
    tick("train2", 32'h40);
    check_eq("ctr_st", 32'(dut.u_bht.ctr[0]), 32'h3);
    stall       = 1'b0;
    ex_br_valid = 1'b0;
    settle();
    check_eq("pred_taken", 32'(pred_taken_o), 32'h1);
    tick("br_taken", 32'h30);
    // 0x30 indexes an untrained counter: falls through
    settle();
    check_eq("pred_nt", 32'(pred_taken_o), 32'h0);
    tick("br_not_taken", 32'h34);
    if_branch = 1'b0;
    if_jal    = 1'b1;
    if_imm    = 32'h100;
    tick("jal", 32'h134);
    clear_in();

    // Mispredict overrides stall and IF-side jal
    stall          = 1'b1;
    if_jal         = 1'b1;
    if_imm         = 32'h40;
    ex_mispredict  = 1'b1;
    ex_redirect_pc = 32'h200;
    settle();
    check_eq("mp_flush", 32'(flush_o), 32'h1);
    tick("mp_stall", 32'h200);
    clear_in();
    settle();
    check_eq("mp_flush_clear", 32'(flush_o), 32'h0);

    // jalr wait
    redirect_to(32'h80);
    if_jalr = 1'b1;
    tick("jalr_enter", 32'h80);
    clear_in();
    if_jal = 1'b1;
    if_imm = 32'h40;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("jwait_hold", 32'(jalr_wait_o), 32'h1);
      tick("jwait_pc", 32'h80);
    end
    clear_in();
    ex_jalr_valid  = 1'b1;
    ex_jalr_target = 32'h1000;
    settle();
    check_eq("jalr_flush", 32'(flush_o), 32'h1);
    tick("jalr_target", 32'h1000);
    clear_in();
    settle();
    check_eq("jalr_run", 32'(jalr_wait_o), 32'h0);

    // jalr resolution while in RUN is ignored
    ex_jalr_valid  = 1'b1;
    ex_jalr_target = 32'h2000;
    settle();
    check_eq("jalr_run_noflush", 32'(flush_o), 32'h0);
    tick("jalr_run_ignored", 32'h1004);
    clear_in();

    // Mispredict and jalr resolution together: mispredict wins
    if_jalr = 1'b1;
    tick("jalr_enter2", 32'h1004);
    clear_in();
    ex_mispredict  = 1'b1;
    ex_redirect_pc = 32'h300;
    ex_jalr_valid  = 1'b1;
    ex_jalr_target = 32'h2000;
    tick("mp_vs_jalr", 32'h300);
    clear_in();
    settle();
    check_eq("mp_vs_jalr_run", 32'(jalr_wait_o), 32'h0);

    // PC wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    tick("pc_wrap", 32'h0);

    // Counter saturation: five not-taken updates on index 2 (PC 0x44)
    stall       = 1'b1;
    ex_br_valid = 1'b1;
    ex_pc       = 32'h44;
    ex_taken    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("sat_hold", 32'h0);
    end
    check_eq("ctr_sat_snt", 32'(dut.u_bht.ctr[2]), 32'h0);
    clear_in();

    // Reset while in JALR_WAIT clears state and the BHT
    if_jalr = 1'b1;
    tick("jalr_enter3", 32'h0);
    clear_in();
    if_is_c = 1'b1;
    tick("jwait_hold2", 32'h0);
    settle();
    check_eq("jwait_pre_rst", 32'(jalr_wait_o), 32'h1);
    rst = 1'b1;
    tick("rst_in_jwait", 32'h0);
    rst = 1'b0;
    settle();
    check_eq("rst_jwait_clr", 32'(jalr_wait_o), 32'h0);
    check_all_wnt("rst2_ctr");
    tick("post_rst_seq", 32'h2);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
